// File: rtl/dual_port_ram_bytewise_wr_pkg.sv
// Shared constants and types for the byte-writable dual-port RAM.
// Byte lanes are BYTE_W wide; the byte-enable vector has one bit per lane.
package dpram_pkg;

    localparam int DPRAM_DATA_WIDTH = 32;
    localparam int BYTE_W           = 8;
    localparam int NUM_BYTES        = DPRAM_DATA_WIDTH / BYTE_W;

    typedef logic [NUM_BYTES-1:0] be_t;

endpackage

// File: rtl/dual_port_ram_bytewise_wr_if.sv
// Port bundle for the RAM: port A is the core read/write path, port B the side read port.
// The master drives requests; the slave (the RAM) returns the registered read data.
interface dual_port_ram_bytewise_wr_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                      enaA;
  logic [DATA_WIDTH/8-1:0]   weA;
  logic [ADDR_WIDTH-1:0]     addrA;
  logic [DATA_WIDTH-1:0]     dinA;
  logic [DATA_WIDTH-1:0]     doutA;
  logic                      enaB;
  logic [ADDR_WIDTH-1:0]     addrB;
  logic [DATA_WIDTH-1:0]     doutB;

  modport master (
    output enaA, weA, addrA, dinA, enaB, addrB,
    input  doutA, doutB
  );

  modport slave (
    input  enaA, weA, addrA, dinA, enaB, addrB,
    output doutA, doutB
  );
endinterface

// File: rtl/dual_port_ram_bytewise_wr_byte_lane.sv
// One byte-wide column of the RAM: write from port A, read-first registered reads on A and B.
// Latency 1 cycle on both read ports; no backpressure, outputs hold while their enable is low.
module dpram_byte_lane
  import dpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ena_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [BYTE_W-1:0]     din_a,
  output logic [BYTE_W-1:0]     dout_a,
  input  logic                  ena_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [BYTE_W-1:0]     dout_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_W-1:0] mem [DEPTH];

  // Array stays out of the reset domain so it maps onto block RAM; reset only blocks writes.
  always_ff @(posedge clk) begin
    if (nrst && ena_a && we_a) begin
      mem[addr_a] <= din_a;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout_a <= '0;
    end else if (ena_a) begin
      dout_a <= mem[addr_a];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dout_b <= '0;
    end else if (ena_b) begin
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/dual_port_ram_bytewise_wr.sv
// Simple dual-port RAM, per-byte writes on port A, read-only port B; 1-cycle read-first reads.
// No backpressure: every enabled edge is served. Optional preload under macro DPRAM_INIT_EN.
module dual_port_ram_bytewise_wr
  import dpram_pkg::*;
#(
  parameter int    ADDR_WIDTH = 12,
  parameter int    DATA_WIDTH = DPRAM_DATA_WIDTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                        clk,
  input  logic                        nrst,
  dual_port_ram_bytewise_wr_if.slave  bus
);

  localparam int LANES = DATA_WIDTH / BYTE_W;

  logic [DATA_WIDTH-1:0] dout_a;
  logic [DATA_WIDTH-1:0] dout_b;

  assign bus.doutA = dout_a;
  assign bus.doutB = dout_b;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dpram_byte_lane #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk    (clk),
      .nrst   (nrst),
      .ena_a  (bus.enaA),
      .we_a   (bus.weA[i]),
      .addr_a (bus.addrA),
      .din_a  (bus.dinA[i*BYTE_W +: BYTE_W]),
      .dout_a (dout_a[i*BYTE_W +: BYTE_W]),
      .ena_b  (bus.enaB),
      .addr_b (bus.addrB),
      .dout_b (dout_b[i*BYTE_W +: BYTE_W])
    );

`ifdef DPRAM_INIT_EN
    // Each lane starts from an all-zero byte column.
    initial begin : init_lane
      for (int k = 0; k < 2**ADDR_WIDTH; k++) u_lane.mem[k] = '0;
    end
`endif
  end

  // The image name has no effect on the hardware.
  if (INIT_FILE != "") begin : g_image_ignored
  end

endmodule

// File: tb/tb_dual_port_ram_bytewise_wr.sv
// Randomised and directed bench for dual_port_ram_bytewise_wr against a word-level memory model.
module tb_dual_port_ram_bytewise_wr;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  logic clk;
  logic nrst;

  dual_port_ram_bytewise_wr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dual_port_ram_bytewise_wr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: memory words plus which bytes have a defined value.
  logic [31:0] mdl [DEPTH];
  logic [3:0]  vld [DEPTH];
  logic [31:0] exp_a, exp_b;
  logic [3:0]  known_a, known_b;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] v);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{v[b]}};
    return m;
  endfunction

  // Drive one cycle of traffic, step the model, then compare both outputs after the edge.
  task automatic op(input string tag, input logic ea, input logic [3:0] we, input logic [AW-1:0] aa,
                    input logic [31:0] da, input logic eb, input logic [AW-1:0] ab);
    logic [31:0] m;
    bus.enaA = ea; bus.weA = we; bus.addrA = aa; bus.dinA = da;
    bus.enaB = eb; bus.addrB = ab;
    if (ea) begin exp_a = mdl[aa]; known_a = vld[aa]; end
    if (eb) begin exp_b = mdl[ab]; known_b = vld[ab]; end
    if (ea) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mdl[aa][8*b +: 8] = da[8*b +: 8];
          vld[aa][b] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    m = byte_mask(known_a);
    if (known_a != 4'h0) check({tag, ".doutA"}, bus.doutA & m, exp_a & m);
    m = byte_mask(known_b);
    if (known_b != 4'h0) check({tag, ".doutB"}, bus.doutB & m, exp_b & m);
  endtask

  task automatic model_reset();
    exp_a = '0; exp_b = '0; known_a = 4'hF; known_b = 4'hF;
  endtask

  logic [AW-1:0] pool [8];
  logic [AW-1:0] ra, rb;

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      mdl[k] = '0;
`ifdef DPRAM_INIT_EN
      vld[k] = 4'hF;
`else
      vld[k] = 4'h0;
`endif
    end
    model_reset();

    // Reset with a write pending: outputs stay zero and the write never lands.
    nrst = 1'b0;
    bus.enaA = 1'b1; bus.weA = 4'hF; bus.addrA = 12'h010; bus.dinA = 32'hDEADBEEF;
    bus.enaB = 1'b1; bus.addrB = 12'h010;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("rst.doutA", bus.doutA, 32'h0);
      check("rst.doutB", bus.doutB, 32'h0);
    end
    nrst = 1'b1;
    op("rst_rd", 1'b1, 4'h0, 12'h010, 32'h0, 1'b0, 12'h000);
    check("rst_drop", {31'd0, bus.doutA == 32'hDEADBEEF}, 32'd0);

    // Full word write then read.
    op("wr_a3", 1'b1, 4'hF, 12'h0A3, 32'h12345678, 1'b0, 12'h000);
    op("rd_a3", 1'b1, 4'h0, 12'h0A3, 32'h0, 1'b0, 12'h000);
    check("full_word", bus.doutA, 32'h12345678);

    // Sparse byte enables.
    op("wr_b5", 1'b1, 4'b0101, 12'h0A3, 32'hAABBCCDD, 1'b0, 12'h000);
    check("wr_b5_rdfirst", bus.doutA, 32'h12345678);
    op("rd_b5", 1'b1, 4'h0, 12'h0A3, 32'h0, 1'b1, 12'h0A3);
    check("byte_lane", bus.doutA, 32'h12BB56DD);

    // Collision: same-edge B read sees the old word.
    op("init_20", 1'b1, 4'hF, 12'h020, 32'h11111111, 1'b0, 12'h000);
    op("coll", 1'b1, 4'hF, 12'h020, 32'h22222222, 1'b1, 12'h020);
    check("coll.A_old", bus.doutA, 32'h11111111);
    check("coll.B_old", bus.doutB, 32'h11111111);
    op("coll_nxt", 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h020);
    check("coll.B_new", bus.doutB, 32'h22222222);

    // Enable hold: disabled ports neither read nor write.
    op("holdB", 1'b0, 4'hF, 12'h020, 32'h33333333, 1'b0, 12'h0A3);
    check("holdB", bus.doutB, 32'h22222222);
    op("holdA_rd", 1'b1, 4'h0, 12'h020, 32'h0, 1'b0, 12'h0A3);
    check("enaA0_nowr", bus.doutA, 32'h22222222);

    // Address extremes.
    op("wr_fff", 1'b1, 4'hF, 12'hFFF, 32'hCAFEF00D, 1'b0, 12'h000);
    op("wr_000", 1'b1, 4'hF, 12'h000, 32'h0BADC0DE, 1'b0, 12'h000);
    op("rd_fff", 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'hFFF);
    check("ext_fff", bus.doutB, 32'hCAFEF00D);
    op("rd_000", 1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h000);
    check("ext_000", bus.doutB, 32'h0BADC0DE);

    // Mid-run reset while writing: write dropped, outputs clear at once.
    op("wr_55", 1'b1, 4'hF, 12'h055, 32'hA5A5A5A5, 1'b1, 12'h055);
    bus.enaA = 1'b1; bus.weA = 4'hF; bus.addrA = 12'h055; bus.dinA = 32'h5A5A5A5A;
    nrst = 1'b0;
    #1;
    check("arst.doutA", bus.doutA, 32'h0);
    @(posedge clk);
    #1;
    check("arst.doutB", bus.doutB, 32'h0);
    model_reset();
    nrst = 1'b1;
    op("rd_55", 1'b1, 4'h0, 12'h055, 32'h0, 1'b0, 12'h000);
    check("arst_drop", bus.doutA, 32'hA5A5A5A5);

    // Random traffic over a small address pool so collisions and overwrites are frequent.
    pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h020; pool[3] = 12'h0A3;
    pool[4] = 12'h055; pool[5] = 12'h7FF; pool[6] = 12'h800; pool[7] = 12'h001;
    for (int n = 0; n < 600; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
      rb = ($urandom_range(0, 2) == 0) ? ra : pool[$urandom_range(0, 7)];
      op("rnd", $urandom_range(0, 3) != 0, 4'($urandom), ra, $urandom,
         $urandom_range(0, 3) != 0, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
